// File: rtl/rope_scheduler.sv
// rtl/rope_scheduler.sv - multi-head RoPE job sequencer with parameter check and watchdog
//
// Takes one multi-head command and issues one RoPE engine job per head: all Q
// heads, then all K heads unless skip_k is set. Every job rotates in place, so
// src and dst are the same SRAM0 base.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   q_base, k_base          SRAM0 base of head 0 for Q and K
//   head_stride, num_heads  head spacing and head count
//   num_rows, head_dim, pos_offset, sin_base, cos_base
//                           forwarded unchanged to every engine job
//   skip_k                  1 = Q heads only
//   eng_cmd_valid/ready     engine command handshake
//   eng_src_base/dst_base   current head base (identical)
//   eng_num_rows..cos_base  latched command fields
//   eng_done                engine job-complete pulse
//   busy, done, err_code    status; err_code 0 ok, 1 bad params, 2 timeout
//   cur_head, cur_pass      head in flight, 0 = Q pass / 1 = K pass
module rope_scheduler #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] q_base,
    input  logic [15:0] k_base,
    input  logic [15:0] head_stride,
    input  logic [7:0]  num_heads,
    input  logic [15:0] num_rows,
    input  logic [15:0] head_dim,
    input  logic [15:0] pos_offset,
    input  logic [15:0] sin_base,
    input  logic [15:0] cos_base,
    input  logic        skip_k,
    output logic        eng_cmd_valid,
    input  logic        eng_cmd_ready,
    output logic [15:0] eng_src_base,
    output logic [15:0] eng_dst_base,
    output logic [15:0] eng_num_rows,
    output logic [15:0] eng_head_dim,
    output logic [15:0] eng_pos_offset,
    output logic [15:0] eng_sin_base,
    output logic [15:0] eng_cos_base,
    input  logic        eng_done,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  cur_head,
    output logic        cur_pass
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    // The counter holds the number of idle WAIT cycles already elapsed, so the
    // cycle that sees WD_LAST is the one that brings it to TIMEOUT.
    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [2:0]  state;
    logic [15:0] q_base_r;
    logic [15:0] k_base_r;
    logic [15:0] stride_r;
    logic [7:0]  num_heads_r;
    logic        skip_k_r;
    logic [15:0] cur_base;
    logic [31:0] wd_cnt;
    logic        bad_params;

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign eng_cmd_valid = (state == S_ISSUE);
    assign eng_src_base  = cur_base;
    assign eng_dst_base  = cur_base;

    assign bad_params = (num_heads_r == 8'd0) || (eng_num_rows == 16'd0) ||
                        (eng_head_dim == 16'd0) || eng_head_dim[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            q_base_r       <= '0;
            k_base_r       <= '0;
            stride_r       <= '0;
            num_heads_r    <= '0;
            skip_k_r       <= 1'b0;
            eng_num_rows   <= '0;
            eng_head_dim   <= '0;
            eng_pos_offset <= '0;
            eng_sin_base   <= '0;
            eng_cos_base   <= '0;
            cur_base       <= '0;
            cur_head       <= '0;
            cur_pass       <= 1'b0;
            err_code       <= 2'd0;
            wd_cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        q_base_r       <= q_base;
                        k_base_r       <= k_base;
                        stride_r       <= head_stride;
                        num_heads_r    <= num_heads;
                        skip_k_r       <= skip_k;
                        eng_num_rows   <= num_rows;
                        eng_head_dim   <= head_dim;
                        eng_pos_offset <= pos_offset;
                        eng_sin_base   <= sin_base;
                        eng_cos_base   <= cos_base;
                        err_code       <= 2'd0;
                        state          <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_params) begin
                        err_code <= 2'd1;
                        state    <= S_DONE;
                    end else begin
                        cur_head <= 8'd0;
                        cur_pass <= 1'b0;
                        cur_base <= q_base_r;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng_cmd_ready) begin
                        wd_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // eng_done wins over a watchdog expiry in the same cycle.
                    if (eng_done) begin
                        if (cur_head != num_heads_r - 8'd1) begin
                            cur_head <= cur_head + 8'd1;
                            cur_base <= cur_base + stride_r;
                            state    <= S_ISSUE;
                        end else if (!cur_pass && !skip_k_r) begin
                            cur_pass <= 1'b1;
                            cur_head <= 8'd0;
                            cur_base <= k_base_r;
                            state    <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (WD_EN) begin
                        if (wd_cnt == WD_LAST) begin
                            err_code <= 2'd2;
                            state    <= S_DONE;
                        end else begin
                            wd_cnt <= wd_cnt + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rope_scheduler.sv
// tb/tb_rope_scheduler.sv - scoreboard bench for rope_scheduler
module tb_rope_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] q_base, k_base, head_stride;
    logic [7:0]  num_heads;
    logic [15:0] num_rows, head_dim, pos_offset, sin_base, cos_base;
    logic        skip_k;
    logic        eng_cmd_valid;
    logic        eng_cmd_ready;
    logic [15:0] eng_src_base, eng_dst_base;
    logic [15:0] eng_num_rows, eng_head_dim, eng_pos_offset, eng_sin_base, eng_cos_base;
    logic        eng_done;
    logic        busy, done;
    logic [1:0]  err_code;
    logic [7:0]  cur_head;
    logic        cur_pass;

    always #5 clk = ~clk;

    rope_scheduler #(.TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .q_base(q_base), .k_base(k_base), .head_stride(head_stride),
        .num_heads(num_heads), .num_rows(num_rows), .head_dim(head_dim),
        .pos_offset(pos_offset), .sin_base(sin_base), .cos_base(cos_base),
        .skip_k(skip_k),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_src_base(eng_src_base), .eng_dst_base(eng_dst_base),
        .eng_num_rows(eng_num_rows), .eng_head_dim(eng_head_dim),
        .eng_pos_offset(eng_pos_offset), .eng_sin_base(eng_sin_base),
        .eng_cos_base(eng_cos_base), .eng_done(eng_done),
        .busy(busy), .done(done), .err_code(err_code),
        .cur_head(cur_head), .cur_pass(cur_pass)
    );

    typedef struct packed {
        logic        pass;
        logic [7:0]  head;
        logic [15:0] base;
    } job_t;

    job_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_at = -1;
    int          hs_cycle = -1;
    int          last_eng_done = -1;
    int          done_cycle = -1;
    int          acc_cycle = -1;
    int          first_valid = -1;
    int          valid_cnt = 0;
    int          done_cnt = 0;
    int          ready_low = 0;
    bit          hang = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_src = '0;
    logic [1:0]  last_err = '0;
    logic [15:0] t_rows, t_hd;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive engine inputs, then observe the cycle's outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        eng_done = (cyc == done_at);
        if (eng_done) last_eng_done = cyc;
        if (eng_cmd_valid && ready_low > 0) begin
            eng_cmd_ready = 1'b0;
            ready_low--;
        end else begin
            eng_cmd_ready = 1'b1;
        end
        if (prev_stall) begin
            check("hold_valid", 32'(eng_cmd_valid), 32'd1);
            check("hold_src", 32'(eng_src_base), 32'(prev_src));
        end
        prev_stall = eng_cmd_valid && !eng_cmd_ready;
        prev_src   = eng_src_base;
        if (eng_cmd_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (eng_cmd_valid && eng_cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_job", 32'd1, 32'd0);
            end else begin
                job_t j;
                j = exp_q.pop_front();
                check("job_base", 32'(eng_src_base), 32'(j.base));
                check("job_dst", 32'(eng_dst_base), 32'(j.base));
                check("job_pass", 32'(cur_pass), 32'(j.pass));
                check("job_head", 32'(cur_head), 32'(j.head));
                check("job_rows", 32'(eng_num_rows), 32'(t_rows));
                check("job_hdim", 32'(eng_head_dim), 32'(t_hd));
                check("job_fwd", {eng_pos_offset, eng_sin_base ^ eng_cos_base}, {16'h0123, 16'h4000 ^ 16'h5000});
            end
            hs_cycle = cyc;
            if (!hang) done_at = cyc + 10;
        end
        if (done) begin
            done_cnt++;
            last_err   = err_code;
            done_cycle = cyc;
        end
    endtask

    task automatic send(input logic [15:0] qb, input logic [15:0] kb, input logic [15:0] st,
                        input logic [7:0] nh, input logic [15:0] rows, input logic [15:0] hd,
                        input logic sk);
        logic [15:0] b;
        q_base = qb; k_base = kb; head_stride = st; num_heads = nh;
        num_rows = rows; head_dim = hd; skip_k = sk;
        t_rows = rows; t_hd = hd;
        first_valid = -1; valid_cnt = 0; done_cnt = 0; done_cycle = -1;
        if (!(nh == 8'd0 || rows == 16'd0 || hd == 16'd0 || hd[0])) begin
            for (int p = 0; p < (sk ? 1 : 2); p++) begin
                b = (p == 0) ? qb : kb;
                for (int h = 0; h < int'(nh); h++) begin
                    exp_q.push_back({p[0], 8'(h), b});
                    b = b + st;
                end
            end
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        acc_cycle = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        tick();
        check("done_one_pulse", 32'(done_cnt), 32'd1);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("jobs_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int hs0;
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; eng_cmd_ready = 1'b1; eng_done = 1'b0;
        q_base = '0; k_base = '0; head_stride = '0; num_heads = '0;
        num_rows = '0; head_dim = '0; skip_k = 1'b0;
        pos_offset = 16'h0123; sin_base = 16'h4000; cos_base = 16'h5000;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_status", {busy, done, err_code, eng_cmd_valid, cur_pass}, 32'd0);
        check("rst_payload", {eng_src_base, eng_num_rows}, 32'd0);
        check("rst_head", 32'(cur_head), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic Q+K run, two heads
        send(16'h0000, 16'h0100, 16'h0040, 8'd2, 16'd4, 16'd64, 1'b0);
        run_until_done(200);
        check("basic_first_issue", 32'(first_valid), 32'(acc_cycle + 2));
        check("basic_done_lat", 32'(done_cycle), 32'(last_eng_done + 1));
        check("basic_err", 32'(last_err), 32'd0);

        // skip_k, three heads; a second command while busy must be ignored
        send(16'h0200, 16'h0900, 16'h0010, 8'd3, 16'd8, 16'd32, 1'b1);
        q_base = 16'h7777; num_heads = 8'd9; cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_valid = 1'b0;
        run_until_done(200);
        check("skipk_done_lat", 32'(done_cycle), 32'(last_eng_done + 1));
        check("skipk_err", 32'(last_err), 32'd0);

        // Engine backpressure for 5 cycles
        ready_low = 5;
        send(16'h0300, 16'h0000, 16'h0020, 8'd1, 16'd2, 16'd16, 1'b1);
        run_until_done(200);
        check("bp_valid_cycles", 32'(valid_cnt), 32'd6);

        // Bad parameters: odd head_dim, then zero heads
        send(16'h0000, 16'h0100, 16'h0040, 8'd2, 16'd4, 16'd7, 1'b0);
        run_until_done(10);
        check("bad_hd_done_cyc", 32'(done_cycle), 32'(acc_cycle + 2));
        check("bad_hd_err", 32'(last_err), 32'd1);
        check("bad_hd_no_job", 32'(valid_cnt), 32'd0);
        send(16'h0000, 16'h0100, 16'h0040, 8'd0, 16'd4, 16'd8, 1'b0);
        run_until_done(10);
        check("bad_nh_done_cyc", 32'(done_cycle), 32'(acc_cycle + 2));
        check("bad_nh_err", 32'(last_err), 32'd1);
        check("bad_nh_no_job", 32'(valid_cnt), 32'd0);

        // Watchdog: engine never completes
        hang = 1;
        send(16'h0010, 16'h0020, 16'h0000, 8'd1, 16'd1, 16'd2, 1'b1);
        run_until_done(100);
        check("wd_done_cyc", 32'(done_cycle), 32'(hs_cycle + 21));
        check("wd_err", 32'(last_err), 32'd2);
        hang = 0;
        send(16'h0040, 16'h0080, 16'h0004, 8'd1, 16'd2, 16'd2, 1'b0);
        run_until_done(200);
        check("post_wd_err", 32'(last_err), 32'd0);

        // Base accumulator wraps mod 2^16 (FFC0 -> 0000)
        send(16'hFFC0, 16'h1000, 16'h0040, 8'd2, 16'd1, 16'd2, 1'b1);
        run_until_done(200);
        check("wrap_err", 32'(last_err), 32'd0);

        // Reset while waiting on the engine
        send(16'h0000, 16'h0100, 16'h0040, 8'd2, 16'd4, 16'd64, 1'b0);
        hs0 = hs_cycle;
        n = 0;
        while (hs_cycle == hs0 && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_hs_seen", 32'(hs_cycle != hs0), 32'd1);
        repeat (3) tick();
        done_at = -1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_outs", {done, err_code, eng_cmd_valid, cur_pass, cur_head}, 32'd0);
        check("midrst_base", 32'(eng_src_base), 32'd0);
        @(negedge clk);
        check("midrst_hold", {busy, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        exp_q.delete();
        prev_stall = 0;

        send(16'h0500, 16'h0000, 16'h0008, 8'd1, 16'd3, 16'd4, 1'b1);
        run_until_done(200);
        check("recover_err", 32'(last_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
